// File: rtl/dm_debug_mem_port.sv
// -----------------------------------------------------------------------------
// dm_debug_mem_port
//
// Purpose
//   Debug-module memory slave sitting between the core's debug-region bus port
//   and dm_debug_rom. Word accesses are decoded into two windows:
//     - debug ROM (ROM_WORDS words, read-only), served by the external
//       dm_debug_rom through rom_addr/rom_dout. The ROM has a 1-cycle
//       registered read.
//     - debug RAM (RAM_WORDS words, read/write), held here as flops.
//   Every accepted request gets exactly one response on a valid/ready channel,
//   one cycle after acceptance. A second, DM-side port gives the abstract-
//   command logic direct full-word access to the debug RAM.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   req_vld/req_rdy        request handshake
//   req_addr/req_wr        byte address, 1 = write
//   req_wdata/req_strb     write data and byte strobes
//   rsp_vld/rsp_rdy        response handshake
//   rsp_rdata/rsp_err      read data (0 for writes/errors), access error
//   rom_addr/rom_dout      word index to dm_debug_rom, ROM data one cycle later
//   dm_ram_we/idx/wdata    DM-side full-word RAM write
//   dm_ram_rdata           DM-side RAM read, combinational from dm_ram_idx
//
// Configuration
//   DM_DBG_MEM_ERR_RSP_EN  defined: error accesses return rsp_err=1 and
//                          rsp_rdata=0. Undefined: rsp_err is tied 0, error
//                          reads return 0 and error writes are dropped; the
//                          response timing is identical in both builds.
// -----------------------------------------------------------------------------
module dm_debug_mem_port #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] ROM_BASE  = 12'h800,
  parameter int                ROM_WORDS = 29,
  parameter logic [ADDR_W-1:0] RAM_BASE  = 12'h400,
  parameter int                RAM_WORDS = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_strb,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [4:0]        rom_addr,
  input  logic [31:0]       rom_dout,
  input  logic              dm_ram_we,
  input  logic [2:0]        dm_ram_idx,
  input  logic [31:0]       dm_ram_wdata,
  output logic [31:0]       dm_ram_rdata
);

  localparam int WIDX_W = ADDR_W - 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_t;

  // Byte-lane merge for strobed bus writes.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_req_rdy;
  logic                w_rsp_vld;
  logic                w_accept;

  logic [WIDX_W-1:0]   w_word;
  logic [WIDX_W-1:0]   w_rom_off;
  logic [WIDX_W-1:0]   w_ram_off;
  logic                w_aligned;
  logic                w_rom_hit;
  logic                w_ram_hit;
  logic                w_err;
  logic                w_rom_rd;
  logic                w_ram_rd;
  logic                w_ram_wr;
  logic [2:0]          w_ram_idx;
  logic [31:0]         w_bus_rd_word;

  logic [31:0]         r_ram [RAM_WORDS];
  logic [4:0]          r_rom_addr;
  logic                r_rsp_rom;
  logic [31:0]         r_rdata;

  // ---------------------------------------------------------------------------
  // Address decode (request stage)
  // ---------------------------------------------------------------------------
  assign w_word    = req_addr[ADDR_W-1:2];
  assign w_rom_off = w_word - ROM_BASE[ADDR_W-1:2];
  assign w_ram_off = w_word - RAM_BASE[ADDR_W-1:2];
  assign w_aligned = (req_addr[1:0] == 2'b00);

  // The >= base test stops the subtraction from wrapping into the window.
  assign w_rom_hit = (req_addr >= ROM_BASE) && (w_rom_off < WIDX_W'(ROM_WORDS));
  assign w_ram_hit = (req_addr >= RAM_BASE) && (w_ram_off < WIDX_W'(RAM_WORDS));

  assign w_err     = ~w_aligned | (w_rom_hit & req_wr) | ~(w_rom_hit | w_ram_hit);
  assign w_rom_rd  = ~w_err & w_rom_hit & ~req_wr;
  assign w_ram_rd  = ~w_err & ~w_rom_hit & w_ram_hit & ~req_wr;
  assign w_ram_wr  = ~w_err & ~w_rom_hit & w_ram_hit &  req_wr;
  assign w_ram_idx = w_ram_off[2:0];

  always_comb begin
    w_bus_rd_word = 32'h0;
    for (int w = 0; w < RAM_WORDS; w++) begin
      if (w_ram_idx == 3'(w)) w_bus_rd_word = r_ram[w];
    end
  end

  always_comb begin
    dm_ram_rdata = 32'h0;
    for (int w = 0; w < RAM_WORDS; w++) begin
      if (dm_ram_idx == 3'(w)) dm_ram_rdata = r_ram[w];
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_rdy   = 1'b0;
    w_rsp_vld   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_rdy = 1'b1;
        if (req_vld) w_state_nxt = ST_RSP;
      end
      ST_RSP: begin
        w_rsp_vld = 1'b1;
        // Retiring a response while accepting a new one keeps us in RSP.
        w_req_rdy = rsp_rdy;
        if (rsp_rdy && !req_vld) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = req_vld & w_req_rdy;
  assign req_rdy  = w_req_rdy;
  assign rsp_vld  = w_rsp_vld;

  // ---------------------------------------------------------------------------
  // ROM index: new index flows straight through on an accepting ROM read so the
  // ROM registers it at the accept edge; otherwise the last index is held so
  // rom_dout stays stable for the whole response.
  // ---------------------------------------------------------------------------
  assign rom_addr = (w_accept && w_rom_rd) ? w_rom_off[4:0] : r_rom_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rom_addr <= 5'd0;
      r_rsp_rom  <= 1'b0;
    end else if (w_accept) begin
      if (w_rom_rd) r_rom_addr <= w_rom_off[4:0];
      r_rsp_rom <= w_rom_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Response stage: RAM read data is captured at accept (pre-write contents).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) r_rdata <= w_ram_rd ? w_bus_rd_word : 32'h0;
  end

  assign rsp_rdata = !w_rsp_vld ? 32'h0 :
                     r_rsp_rom  ? rom_dout : r_rdata;

`ifdef DM_DBG_MEM_ERR_RSP_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_err <= 1'b0;
    else if (w_accept) r_err <= w_err;
  end

  assign rsp_err = w_rsp_vld & r_err;
`else
  assign rsp_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Debug RAM storage. A DM write to the same word as a bus write takes the
  // whole word, so it is checked first.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < RAM_WORDS; w++) r_ram[w] <= 32'h0;
    end else begin
      for (int w = 0; w < RAM_WORDS; w++) begin
        if (dm_ram_we && (dm_ram_idx == 3'(w))) begin
          r_ram[w] <= dm_ram_wdata;
        end else if (w_accept && w_ram_wr && (w_ram_idx == 3'(w))) begin
          r_ram[w] <= merge_bytes(r_ram[w], req_wdata, req_strb);
        end
      end
    end
  end

endmodule
